// File: rtl/os_recomb_acc.sv
`default_nettype none
// ============================================================================
// Module   : os_recomb_acc
// Purpose  : Recombines Karatsuba-style GF(2) partial products into limb
//            products and overlap-XORs BEATS of them, at W-bit offsets, into
//            one frame result. Define OS_PARITY_EN to add the out_parity port.
// Revision : 1.0  initial release
// ============================================================================
module os_recomb_acc #(
    parameter int W     = 8,
    parameter int BEATS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_z0,
    input  logic [2*W-2:0]           in_z1,
    input  logic [W-1:0]             in_z2,
    input  logic [W-2:0]             in_o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [(BEATS+1)*W-2:0]   out_y
`ifdef OS_PARITY_EN
    ,
    output logic                     out_parity
`endif
);

    localparam int c_aw = (BEATS + 1) * W - 1;
    localparam int c_lw = 2 * W - 1;
    localparam int c_cw = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(BEATS - 1);

    typedef enum logic [0:0] {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_cw-1:0]   r_cnt;
    logic [c_aw-1:0]   r_acc;
    logic [c_lw-1:0]   w_r;
    logic [c_aw-1:0]   w_r_ext;
    logic [c_aw-1:0]   w_acc_nxt;
    logic              w_accept;

    // Every term fits within 2W-1 bits, so the concatenations are exact
    assign w_r = in_z1
               ^ {{(W-1){1'b0}}, in_z0}
               ^ {in_z2, {(W-1){1'b0}}}
               ^ {{W{1'b0}}, in_o}
               ^ {in_o, {W{1'b0}}};

    always_comb begin
        w_r_ext = '0;
        w_r_ext[c_lw-1:0] = w_r;
    end

    // First beat of a frame overwrites acc so no stale upper bits survive
    assign w_acc_nxt = (r_cnt == '0) ? w_r_ext
                                     : (r_acc ^ (w_r_ext << (int'(r_cnt) * W)));

    assign in_ready  = (r_state == S_ACC) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_HOLD);
    assign out_y     = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACC;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        if (r_cnt == c_last) begin
                            r_cnt   <= '0;
                            r_state <= S_HOLD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_ACC;
                    end
                end
                default: r_state <= S_ACC;
            endcase
        end
    end

`ifdef OS_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^w_acc_nxt;
        end
    end

    assign out_parity = r_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_os_recomb_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_os_recomb_acc
// Purpose  : Directed self-checking bench for os_recomb_acc (BEATS=2 and 1).
// Revision : 1.0  initial release
// ============================================================================
module tb_os_recomb_acc;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    // BEATS=2 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_z0, in_z2;
    logic [14:0] in_z1;
    logic [6:0]  in_o;
    logic [22:0] out_y;

    // BEATS=1 instance
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0]  in_z0_1, in_z2_1;
    logic [14:0] in_z1_1;
    logic [6:0]  in_o_1;
    logic [14:0] out_y1;

`ifdef OS_PARITY_EN
    logic        out_parity, out_parity1;
`endif

    always #5 clk = ~clk;

    os_recomb_acc #(.W(8), .BEATS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z0     (in_z0),
        .in_z1     (in_z1),
        .in_z2     (in_z2),
        .in_o      (in_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
`ifdef OS_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    os_recomb_acc #(.W(8), .BEATS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_z0     (in_z0_1),
        .in_z1     (in_z1_1),
        .in_z2     (in_z2_1),
        .in_o      (in_o_1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_y     (out_y1)
`ifdef OS_PARITY_EN
        ,
        .out_parity(out_parity1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] z0, input logic [14:0] z1,
                         input logic [7:0] z2, input logic [6:0] o);
        in_valid = v;
        in_z0    = z0;
        in_z1    = z1;
        in_z2    = z2;
        in_o     = o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'h5A, 15'h1234, 8'hA5, 7'h33);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_y !== 23'h0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: in_ready=%b out_valid=%b out_y=%h, want 0 0 000000",
                         i, in_ready, out_valid, out_y);
            end
        end
`ifdef OS_PARITY_EN
        checks++;
        if (out_parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_parity: got %b want 0", out_parity);
        end
`endif
        rst = 1'b0;
        drive(1'b0, 8'h0, 15'h0, 8'h0, 7'h0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_two_beat();
        out_ready = 1'b1;
        drive(1'b1, 8'h01, 15'h0, 8'h00, 7'h0);
        tick();
        drive(1'b1, 8'h00, 15'h0, 8'h01, 7'h0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL two_beat_early_valid: got %b want 0", out_valid);
        end
        tick();
        drive(1'b0, 8'h0, 15'h0, 8'h0, 7'h0);
        checks++;
        if (out_valid !== 1'b1 || out_y !== 23'h008001) begin
            errors++;
            $display("FAIL two_beat_result: out_valid=%b out_y=%h want 1 008001", out_valid, out_y);
        end
`ifdef OS_PARITY_EN
        checks++;
        if (out_parity !== 1'b0) begin
            errors++;
            $display("FAIL two_beat_parity: got %b want 0", out_parity);
        end
`endif
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL two_beat_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 8'h00, 15'h0000, 8'h00, 7'h01);
        tick();
        drive(1'b1, 8'h00, 15'h7FFF, 8'h00, 7'h00);
        tick();
        // Extra beats offered during HOLD must be ignored
        drive(1'b1, 8'hFF, 15'h5555, 8'hFF, 7'h7F);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_y !== 23'h7FFE01 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d: out_valid=%b out_y=%h in_ready=%b want 1 7ffe01 0",
                         i, out_valid, out_y, in_ready);
            end
`ifdef OS_PARITY_EN
            checks++;
            if (out_parity !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_parity: got %b want 1", out_parity);
            end
`endif
            tick();
        end
        drive(1'b0, 8'h0, 15'h0, 8'h0, 7'h0);
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  z0_tab [6] = '{8'h03, 8'h05, 8'hAA, 8'h00, 8'h00, 8'h00};
        logic        v_tab  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        ov_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [22:0] y_tab  [6] = '{23'h0, 23'h000503, 23'h0, 23'h0, 23'h000000, 23'h0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(v_tab[i], z0_tab[i], 15'h0, 8'h00, 7'h0);
            tick();
            checks++;
            if (out_valid !== ov_tab[i] || (ov_tab[i] && out_y !== y_tab[i])) begin
                errors++;
                $display("FAIL back_to_back slot %0d: out_valid=%b out_y=%h want %b %h",
                         i, out_valid, out_y, ov_tab[i], y_tab[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        drive(1'b1, 8'hFF, 15'h0, 8'h00, 7'h0);
        tick();
        drive(1'b0, 8'h0, 15'h0, 8'h0, 7'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_y !== 23'h0) begin
            errors++;
            $display("FAIL mid_reset_clear: out_valid=%b out_y=%h want 0 000000", out_valid, out_y);
        end
        drive(1'b1, 8'h01, 15'h0, 8'h00, 7'h0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_cnt: out_valid=%b after first beat, want 0", out_valid);
        end
        drive(1'b1, 8'h00, 15'h0, 8'h00, 7'h0);
        tick();
        drive(1'b0, 8'h0, 15'h0, 8'h0, 7'h0);
        checks++;
        if (out_valid !== 1'b1 || out_y !== 23'h000001) begin
            errors++;
            $display("FAIL mid_reset_result: out_valid=%b out_y=%h want 1 000001", out_valid, out_y);
        end
        tick();
    endtask

    task automatic test_reset_hold();
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 15'h0, 8'h00, 7'h0);
        tick();
        tick();
        drive(1'b0, 8'h0, 15'h0, 8'h0, 7'h0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold_setup: out_valid=%b want 1", out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_y !== 23'h0) begin
            errors++;
            $display("FAIL reset_hold_drop: out_valid=%b out_y=%h want 0 000000", out_valid, out_y);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_beats1();
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        in_z0_1    = 8'h01;
        in_z1_1    = 15'h0001;
        in_z2_1    = 8'h80;
        in_o_1     = 7'h40;
        tick();
        in_valid1  = 1'b0;
        checks++;
        if (out_valid1 !== 1'b1 || out_y1 !== 15'h0040 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL beats1_result: out_valid=%b out_y=%h in_ready=%b want 1 0040 0",
                     out_valid1, out_y1, in_ready1);
        end
`ifdef OS_PARITY_EN
        checks++;
        if (out_parity1 !== 1'b1) begin
            errors++;
            $display("FAIL beats1_parity: got %b want 1", out_parity1);
        end
`endif
        tick();
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL beats1_release: out_valid=%b in_ready=%b want 0 1", out_valid1, in_ready1);
        end
    endtask

    initial begin
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        in_z0_1    = 8'h0;
        in_z1_1    = 15'h0;
        in_z2_1    = 8'h0;
        in_o_1     = 7'h0;
        test_reset();
        test_two_beat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_hold();
        test_beats1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
